// File: rtl/guvm_icache_responder.sv
// Instruction-side responder: serves core fetches from a driver-filled FIFO
// with optional wait states, stalling the core while no word is available.
module guvm_icache_responder #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] NOP_WORD    = 32'h01000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                inst_in,
   input  logic                       inst_valid,
   output logic                       inst_ready,
   input  logic                       fetch_req,
   input  logic [31:0]                fetch_addr,
   input  logic                       flush,
   output logic [31:0]                ic_data,
   output logic                       ic_hold,
   output logic                       ic_mds,
   output logic [31:0]                last_addr,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    state_q, state_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   last_q, last_d;
   logic [31:0]   data_q, data_d;
   logic          hold_q, hold_d;
   logic          mds_q, mds_d;
   logic          ovf_q, ovf_d;
   logic          full, nonempty, push, pop, deliver;

   assign full     = (cnt_q == CW'(DEPTH));
   assign nonempty = (cnt_q != '0);

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      last_d  = last_q;
      data_d  = data_q;
      hold_d  = hold_q;
      mds_d   = 1'b0;
      ovf_d   = ovf_q | (inst_valid & full);
      push    = inst_valid & ~full & ~flush;
      pop     = 1'b0;
      deliver = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (fetch_req) begin
               addr_d = fetch_addr;
               if (WAIT_STATES == 0) begin
                  if (nonempty) begin
                     deliver = 1'b1;
                  end else begin
                     hold_d  = 1'b0;
                     state_d = S_STALL;
                  end
               end else begin
                  hold_d  = 1'b0;
                  wcnt_d  = 4'(WAIT_STATES);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            // Last wait cycle: deliver now or fall back to stalling
            if (wcnt_q <= 4'd1) begin
               if (nonempty) deliver = 1'b1;
               else state_d = S_STALL;
            end
         end
         S_STALL: begin
            if (nonempty) deliver = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            hold_d  = 1'b1;
         end
      endcase

      if (deliver) begin
         pop     = 1'b1;
         data_d  = mem_q[rd_q];
         mds_d   = 1'b1;
         last_d  = addr_d;
         hold_d  = 1'b1;
         state_d = S_IDLE;
      end

      if (pop)  rd_d = rd_q + PW'(1);
      if (push) wr_d = wr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      // Flush overrides push, pop and any fetch in progress
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         cnt_d   = '0;
         state_d = S_IDLE;
         hold_d  = 1'b1;
         data_d  = NOP_WORD;
         mds_d   = 1'b0;
         last_d  = last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= inst_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         addr_q  <= '0;
         last_q  <= '0;
         data_q  <= NOP_WORD;
         hold_q  <= 1'b1;
         mds_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
         mds_q   <= mds_d;
         ovf_q   <= ovf_d;
      end
   end

   assign inst_ready = ~full;
   assign fifo_count = cnt_q;
   assign ic_data    = data_q;
   assign ic_hold    = hold_q;
   assign ic_mds     = mds_q;
   assign last_addr  = last_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_guvm_icache_responder.sv
// Bench for guvm_icache_responder: three instances (0/2/3 wait states) share
// stimulus and are checked every cycle against a timestamp-based model.
module tb_guvm_icache_responder;

   localparam logic [31:0] NOP = 32'h01000000;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_in = '0;
   logic        inst_valid = 1'b0;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        flush = 1'b0;

   logic        inst_ready [3];
   logic [31:0] ic_data    [3];
   logic        ic_hold    [3];
   logic        ic_mds     [3];
   logic [31:0] last_addr  [3];
   logic [3:0]  fifo_count [3];
   logic        overflow   [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      guvm_icache_responder #(
         .DEPTH(DEPTH),
         .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
         .NOP_WORD(NOP)
      ) u_dut (
         .clk(clk), .rst(rst),
         .inst_in(inst_in), .inst_valid(inst_valid),
         .inst_ready(inst_ready[g]),
         .fetch_req(fetch_req), .fetch_addr(fetch_addr),
         .flush(flush),
         .ic_data(ic_data[g]), .ic_hold(ic_hold[g]),
         .ic_mds(ic_mds[g]), .last_addr(last_addr[g]),
         .fifo_count(fifo_count[g]), .overflow(overflow[g])
      );
   end

   int total = 0;
   int bad = 0;
   int edge_n = 0;

   // Reference model: a queue of words plus the edge at which a fetch began.
   logic [31:0] mq [3][$];
   bit          busy [3];
   int          f_edge [3];
   logic [31:0] pa [3];
   logic [31:0] m_data [3];
   logic [31:0] m_last [3];
   bit          m_hold [3];
   bit          m_mds [3];
   bit          m_ovf [3];

   function automatic int ws(int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         busy[i] = 0; f_edge[i] = 0; pa[i] = '0;
         m_data[i] = NOP; m_last[i] = '0;
         m_hold[i] = 1; m_mds[i] = 0; m_ovf[i] = 0;
      end
   endtask

   task automatic model_edge();
      bit rdy;
      int avail;
      edge_n++;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         rdy = (mq[i].size() < DEPTH);
         avail = mq[i].size();
         if (inst_valid && !rdy) m_ovf[i] = 1;
         m_mds[i] = 0;
         if (flush) begin
            mq[i].delete();
            busy[i] = 0; m_hold[i] = 1; m_data[i] = NOP;
         end else begin
            if (!busy[i] && fetch_req) begin
               busy[i] = 1; f_edge[i] = edge_n; pa[i] = fetch_addr;
            end
            // A word pushed on an earlier edge is available once the wait is over
            if (busy[i] && edge_n >= f_edge[i] + ws(i) && avail > 0) begin
               m_data[i] = mq[i].pop_front();
               m_mds[i] = 1; m_last[i] = pa[i]; busy[i] = 0;
            end
            if (inst_valid && rdy) mq[i].push_back(inst_in);
            m_hold[i] = !busy[i];
         end
      end
   endtask

   task automatic chk(input string tag, input int i,
                      input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk("ic_data", i, ic_data[i], m_data[i]);
         chk("ic_hold", i, 32'(ic_hold[i]), 32'(m_hold[i]));
         chk("ic_mds", i, 32'(ic_mds[i]), 32'(m_mds[i]));
         chk("last_addr", i, last_addr[i], m_last[i]);
         chk("fifo_count", i, 32'(fifo_count[i]), 32'(mq[i].size()));
         chk("inst_ready", i, 32'(inst_ready[i]), 32'(mq[i].size() < DEPTH));
         chk("overflow", i, 32'(overflow[i]), 32'(m_ovf[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic push(input logic [31:0] w);
      inst_valid = 1; inst_in = w;
      step();
      inst_valid = 0;
   endtask

   task automatic fetch(input logic [31:0] a);
      fetch_req = 1; fetch_addr = a;
      step();
      fetch_req = 0;
   endtask

   task automatic do_flush();
      flush = 1;
      step();
      flush = 0;
   endtask

   initial begin
      model_reset();
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("rst_data", i, ic_data[i], 32'h01000000);
         chk("rst_hold", i, 32'(ic_hold[i]), 32'd1);
         chk("rst_mds", i, 32'(ic_mds[i]), 32'd0);
         chk("rst_ready", i, 32'(inst_ready[i]), 32'd1);
         chk("rst_count", i, 32'(fifo_count[i]), 32'd0);
      end
      rst = 0;
      step(); step();

      // Back-to-back fetches with zero wait states
      push(32'h8E00C002);
      push(32'h82102005);
      fetch(32'h0);
      chk("b2b_mds1", 0, 32'(ic_mds[0]), 32'd1);
      chk("b2b_data1", 0, ic_data[0], 32'h8E00C002);
      fetch(32'h4);
      chk("b2b_mds2", 0, 32'(ic_mds[0]), 32'd1);
      chk("b2b_data2", 0, ic_data[0], 32'h82102005);
      chk("b2b_last", 0, last_addr[0], 32'h4);
      chk("b2b_count", 0, 32'(fifo_count[0]), 32'd0);
      for (int k = 0; k < 5; k++) step();
      do_flush();

      // Two wait states
      push(32'h12345678);
      fetch(32'h40);
      chk("ws2_hold_a", 1, 32'(ic_hold[1]), 32'd0);
      step();
      chk("ws2_hold_b", 1, 32'(ic_hold[1]), 32'd0);
      step();
      chk("ws2_mds", 1, 32'(ic_mds[1]), 32'd1);
      chk("ws2_data", 1, ic_data[1], 32'h12345678);
      for (int k = 0; k < 3; k++) step();

      // Fetch from an empty FIFO stalls until one cycle after the push
      fetch(32'h80);
      for (int k = 0; k < 5; k++) step();
      push(32'h90102001);
      for (int i = 0; i < 3; i++)
         chk("stall_hold", i, 32'(ic_hold[i]), 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("stall_mds", i, 32'(ic_mds[i]), 32'd1);
         chk("stall_data", i, ic_data[i], 32'h90102001);
      end
      step();

      // Fill past capacity, then drain
      for (int k = 1; k <= 9; k++) begin
         push(32'hA0000000 + 32'(k));
         if (k == 8) chk("full_ready", 0, 32'(inst_ready[0]), 32'd0);
      end
      chk("full_count", 0, 32'(fifo_count[0]), 32'd8);
      chk("full_ovf", 0, 32'(overflow[0]), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         fetch(32'h1000 + 32'(4 * k));
         chk("drain_data", 0, ic_data[0], 32'hA0000000 + 32'(k));
      end
      do_flush();
      chk("ovf_sticky", 0, 32'(overflow[0]), 32'd1);

      // Flush during the wait states
      push(32'hB0000001); push(32'hB0000002); push(32'hB0000003);
      fetch(32'h100);
      step();
      do_flush();
      chk("fl_hold", 2, 32'(ic_hold[2]), 32'd1);
      chk("fl_count", 2, 32'(fifo_count[2]), 32'd0);
      chk("fl_data", 2, ic_data[2], 32'h01000000);
      chk("fl_mds", 2, 32'(ic_mds[2]), 32'd0);
      push(32'hC0FFEE00);
      fetch(32'h200);
      step(); step(); step();
      chk("post_fl_mds", 2, 32'(ic_mds[2]), 32'd1);
      chk("post_fl_data", 2, ic_data[2], 32'hC0FFEE00);
      chk("post_fl_last", 2, last_addr[2], 32'h200);
      step();

      // Asynchronous reset in the middle of a stalled fetch
      fetch(32'h300);
      rst = 1;
      #1;
      model_reset();
      check_all();
      #1 rst = 0;
      step();

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         inst_valid = ($urandom_range(2) == 0);
         inst_in    = $urandom;
         fetch_req  = $urandom_range(1) == 1;
         fetch_addr = $urandom & 32'hFFFF_FFFC;
         flush      = ($urandom_range(39) == 0);
         step();
      end
      inst_valid = 0; fetch_req = 0; flush = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/guvm_icache_responder.md
# guvm_icache_responder

Instruction-side memory responder for the GUVM core bench. It answers the integer unit's instruction fetch requests and returns instruction words through the same data/hold/mds signals the core consumes from its instruction cache. The words come from a FIFO that the GUVM driver fills. It sits between the driver clocking block and the core's icache output port, replacing the static `icache_output.data` assignment with a stall-aware fetch handshake.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in words; power of two, ≥2.
- WAIT_STATES, 0, extra cycles inserted before each delivery; 0..15.
- NOP_WORD, 32'h01000000, SPARC `nop`; value of ic_data out of reset and after flush.

Ports:
- clk  in  1  bench clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_in  in  32  instruction word from the driver.
- inst_valid  in  1  driver push strobe; accepted when inst_ready=1.
- inst_ready  out  1  FIFO not full (registered count < DEPTH).
- fetch_req  in  1  core fetch strobe; sampled only in IDLE.
- fetch_addr  in  32  fetch address; latched with fetch_req.
- flush  in  1  empties FIFO and aborts any pending fetch.
- ic_data  out  32  instruction word to core (registered).
- ic_hold  out  1  1 = no stall; 0 = core must stall.
- ic_mds  out  1  one-cycle pulse, ic_data carries a new word.
- last_addr  out  32  address of the last delivered fetch, for the monitor.
- fifo_count  out  $clog2(DEPTH+1)  words held.
- overflow  out  1  sticky; push attempted while full.

## Operation
- FSM states: IDLE, WAIT, STALL.
- IDLE: ic_hold=1.
  - On fetch_req, latch fetch_addr.
  - If WAIT_STATES=0 and FIFO is non-empty: pop in the same edge, load ic_data with the head word, pulse ic_mds, update last_addr, stay in IDLE.
  - Otherwise: ic_hold←0, wait counter←WAIT_STATES, go to WAIT.
- WAIT: counter decrements each cycle. At counter 0:
  - FIFO non-empty: pop, load ic_data, pulse ic_mds, update last_addr, ic_hold←1, go to IDLE.
  - FIFO empty: go to STALL.
- STALL: ic_hold stays 0. On the first cycle with the FIFO non-empty, deliver exactly as WAIT does at counter 0.
- fetch_req outside IDLE is ignored, because the core is held.
- FIFO: circular, pointer width log2(DEPTH), pointers wrap silently.
  - Push when inst_valid && inst_ready.
  - Push and pop in the same edge are both performed; the count is unchanged.
  - A word pushed into an empty FIFO becomes poppable on the following edge (no bypass).
- Full: inst_ready=0. inst_valid=1 while full drops the word and sets overflow. A pop in that same cycle does not make room for the push.
- Flush: highest priority over push, pop and fetch in the same edge.
  - Pointers and count←0.
  - State←IDLE, ic_hold←1, ic_data←NOP_WORD, no ic_mds pulse.
  - overflow and last_addr are preserved.
- ic_data holds its last delivered value between deliveries.

## Timing
- Reset values: ic_data=NOP_WORD, ic_hold=1, ic_mds=0, inst_ready=1, fifo_count=0, last_addr=0, overflow=0, state IDLE, FIFO empty.
- Reset mid-fetch returns to the reset values immediately (asynchronous). Any pending fetch is lost.
- Delivery latency, with fetch_req sampled at edge N and the FIFO non-empty: ic_data valid and ic_mds=1 during cycle N+1+WAIT_STATES.
  - For WAIT_STATES>0, ic_hold is 0 for exactly WAIT_STATES cycles.
- Empty FIFO: ic_hold stays 0 until one cycle after the first push edge, then delivery. Earliest delivery is edge P+1 for a push at edge P.
- ic_mds is never high for two consecutive cycles when WAIT_STATES>0. With WAIT_STATES=0, back-to-back fetches give back-to-back pulses.
- inst_ready, fifo_count and overflow are registered and update one edge after the causing event.

## Test plan
- Reset, then idle: ic_data=32'h01000000, ic_hold=1, ic_mds=0, inst_ready=1, fifo_count=0.
- WAIT_STATES=0; push 32'h8E00C002 and 32'h82102005; two consecutive fetch_req at 0x0 and 0x4.
  - ic_mds pulses on two consecutive cycles with those words in order.
  - last_addr=0x4, ic_hold stays 1 throughout, fifo_count returns to 0.
- WAIT_STATES=2; push one word; fetch_req at edge N.
  - ic_hold=0 for cycles N+1..N+2; word and ic_mds appear in cycle N+3.
- Empty FIFO; fetch_req; 5 idle cycles; then push 32'h90102001.
  - ic_hold stays 0 until delivery one cycle after the push edge; ic_mds pulses once.
- DEPTH=8: push 9 words without fetching.
  - inst_ready=0 after the 8th push, 9th word dropped, overflow=1, fifo_count=8.
  - Then 8 fetches return words 1–8 in order.
- Push 3 words; fetch_req with WAIT_STATES=3; assert flush during WAIT.
  - Next cycle: ic_hold=1, fifo_count=0, ic_data=32'h01000000, no ic_mds.
  - A following push and fetch delivers normally.
